// File: rtl/elevator_vga_pkg.sv
// Shared constants, types and helpers for the elevator shaft pixel generator.
// Geometry is fixed here so the car animator and the pixel pipeline agree on
// every row and column they compare against.
package elevator_vga_pkg;

  // 640x480 VGA timing (the counters come from the upstream timing controller)
  localparam int H_ACTIVE      = 640;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_PULSE  = 96;
  localparam int H_BACK_PORCH  = 48;
  localparam int H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_ACTIVE      = 480;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_PULSE  = 2;
  localparam int V_BACK_PORCH  = 33;
  localparam int V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  // Shaft geometry. NUM_FLOORS is limited to 4 by the 2-bit floor request.
  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_H    = 120;
  localparam int SHAFT_X0   = 280;
  localparam int CAR_W      = 80;
  localparam int CAR_H      = 100;
  localparam int SLEW       = 1;
  localparam int DOOR_STEP  = 2;

  // Door gap is measured from the car centre outwards, so full open is half the width
  localparam int DOOR_FULL  = CAR_W / 2;
  localparam int CAR_CENTRE = SHAFT_X0 + CAR_W / 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    OPENING = 3'd2,
    OPEN    = 3'd3,
    CLOSING = 3'd4
  } car_state_t;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  // Region flags captured by the first pixel pipeline stage
  typedef struct packed {
    logic active;
    logic in_shaft;
    logic in_car;
    logic in_gap;
    logic on_floor_line;
  } pix_flags_t;

  localparam rgb12_t COLOUR_BLACK = '{red: 4'h0, green: 4'h0, blue: 4'h0};
  localparam rgb12_t COLOUR_GAP   = '{red: 4'hF, green: 4'hC, blue: 4'h0};
  localparam rgb12_t COLOUR_DOOR  = '{red: 4'h8, green: 4'h8, blue: 4'h8};
  localparam rgb12_t COLOUR_FLOOR = '{red: 4'hF, green: 4'hF, blue: 4'hF};
  localparam rgb12_t COLOUR_SHAFT = '{red: 4'h0, green: 4'h0, blue: 4'h4};

  // Top line of the car when parked at floor f (floor 0 is the bottom of the screen);
  // the car is centred vertically inside its floor band.
  function automatic logic [9:0] floor_top(input int f);
    return 10'((NUM_FLOORS - 1 - f) * FLOOR_H + (FLOOR_H - CAR_H) / 2);
  endfunction

  // Colour priority: blanking, door gap, closed door, floor line, empty shaft
  function automatic rgb12_t pixel_colour(input pix_flags_t f);
    rgb12_t c;
    if (!f.active) begin
      c = COLOUR_BLACK;
    end else if (f.in_gap) begin
      c = COLOUR_GAP;
    end else if (f.in_car) begin
      c = COLOUR_DOOR;
    end else if (f.on_floor_line) begin
      c = COLOUR_FLOOR;
    end else if (f.in_shaft) begin
      c = COLOUR_SHAFT;
    end else begin
      c = COLOUR_BLACK;
    end
    return c;
  endfunction

endpackage

// File: rtl/elevator_pixel_gen_if.sv
// VGA-side bus of the pixel generator: timing controller counters/syncs in,
// RGB and re-aligned syncs out. The master is whatever drives the counters.
interface elevator_pixel_gen_if;

  logic [9:0] horiz_count;
  logic [9:0] vert_count;
  logic       hsync_in;
  logic       vsync_in;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output horiz_count,
    output vert_count,
    output hsync_in,
    output vsync_in,
    input  red,
    input  green,
    input  blue,
    input  hsync_out,
    input  vsync_out
  );

  modport slave (
    input  horiz_count,
    input  vert_count,
    input  hsync_in,
    input  vsync_in,
    output red,
    output green,
    output blue,
    output hsync_out,
    output vsync_out
  );

endinterface

// File: rtl/elevator_car_anim.sv
// Car animator: one state update per frame tick. Moves the car one slew step
// toward the requested floor and sequences the doors when parked. The car only
// ever leaves IDLE toward MOVE, and IDLE is only re-entered with the doors shut,
// so the car cannot travel with a door gap.
module elevator_car_anim
  import elevator_vga_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       i_tick,
  input  logic [1:0] i_sim_state,
  input  logic       i_door_req,
  output logic [8:0] o_car_y,
  output logic [9:0] o_door_gap,
  output logic       o_at_target
);

  localparam logic [9:0] GAP_FULL = 10'(DOOR_FULL);
  localparam logic [9:0] GAP_STEP = 10'(DOOR_STEP);
  localparam logic [8:0] SLEW_9   = 9'(SLEW);
  localparam logic [8:0] HOME_Y   = 9'(floor_top(0));

  car_state_t r_state;
  car_state_t w_state_next;
  logic [8:0] r_car_y;
  logic [8:0] w_car_y_next;
  logic [9:0] r_door_gap;
  logic [9:0] w_door_gap_next;
  logic       r_at_target;
  logic       w_at_target_next;

  // Parking rows per request code; codes beyond the last floor alias the top floor
  logic [9:0] w_floor_tops [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_floor_top
    if (gi < NUM_FLOORS) begin : g_real
      assign w_floor_tops[gi] = floor_top(gi);
    end else begin : g_alias
      assign w_floor_tops[gi] = floor_top(NUM_FLOORS - 1);
    end
  end

  logic [1:0] w_target;
  logic [9:0] w_dest;
  logic [9:0] w_car_y10;
  logic       w_at_dest;
  logic       w_dest_above;
  logic [8:0] w_dist;
  logic [8:0] w_step;
  logic [8:0] w_stepped_y;
  logic       w_stepped_done;
  logic [9:0] w_gap_opened;
  logic [9:0] w_gap_closed;

  assign w_target  = (int'(i_sim_state) >= NUM_FLOORS) ? 2'(NUM_FLOORS - 1) : i_sim_state;
  assign w_dest    = w_floor_tops[w_target];
  assign w_car_y10 = {1'b0, r_car_y};
  assign w_at_dest = (w_car_y10 == w_dest);

  // Upward travel means car_y decreases; step is min(SLEW, remaining distance)
  assign w_dest_above   = (w_dest < w_car_y10);
  assign w_dist         = w_dest_above ? (r_car_y - w_dest[8:0]) : (w_dest[8:0] - r_car_y);
  assign w_step         = (w_dist < SLEW_9) ? w_dist : SLEW_9;
  assign w_stepped_y    = w_dest_above ? (r_car_y - w_step) : (r_car_y + w_step);
  assign w_stepped_done = ({1'b0, w_stepped_y} == w_dest);

  // Door gap moves in fixed steps, saturating at fully open and at shut
  assign w_gap_opened = ((r_door_gap + GAP_STEP) >= GAP_FULL) ? GAP_FULL : (r_door_gap + GAP_STEP);
  assign w_gap_closed = (r_door_gap <= GAP_STEP) ? 10'd0 : (r_door_gap - GAP_STEP);

  // Next-state logic: every transition also applies its first step in the same tick
  always_comb begin
    w_state_next    = r_state;
    w_car_y_next    = r_car_y;
    w_door_gap_next = r_door_gap;
    if (i_tick) begin
      unique case (r_state)
        IDLE: begin
          if (!w_at_dest) begin
            w_car_y_next = w_stepped_y;
            w_state_next = w_stepped_done ? IDLE : MOVE;
          end else if (i_door_req) begin
            w_door_gap_next = w_gap_opened;
            w_state_next    = (w_gap_opened == GAP_FULL) ? OPEN : OPENING;
          end
        end
        MOVE: begin
          // A changed request simply changes w_dest, which retargets and may reverse
          w_car_y_next = w_stepped_y;
          w_state_next = w_stepped_done ? IDLE : MOVE;
        end
        OPENING: begin
          // A new floor request also aborts opening: the doors must shut before travel
          if (!i_door_req || !w_at_dest) begin
            w_door_gap_next = w_gap_closed;
            w_state_next    = (w_gap_closed == 10'd0) ? IDLE : CLOSING;
          end else begin
            w_door_gap_next = w_gap_opened;
            w_state_next    = (w_gap_opened == GAP_FULL) ? OPEN : OPENING;
          end
        end
        OPEN: begin
          if (!i_door_req || !w_at_dest) begin
            w_door_gap_next = w_gap_closed;
            w_state_next    = (w_gap_closed == 10'd0) ? IDLE : CLOSING;
          end
        end
        CLOSING: begin
          w_door_gap_next = w_gap_closed;
          w_state_next    = (w_gap_closed == 10'd0) ? IDLE : CLOSING;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Arrival flag follows the position being committed in the same tick
  assign w_at_target_next = i_tick ? ({1'b0, w_car_y_next} == w_dest) : r_at_target;

  // State and animation registers; reset parks the car at the bottom floor
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_car_y     <= HOME_Y;
      r_door_gap  <= 10'd0;
      r_at_target <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_car_y     <= w_car_y_next;
      r_door_gap  <= w_door_gap_next;
      r_at_target <= w_at_target_next;
    end
  end

  assign o_car_y     = r_car_y;
  assign o_door_gap  = r_door_gap;
  assign o_at_target = r_at_target;

endmodule

// File: rtl/elevator_pixel_gen.sv
// Pixel generator for one elevator shaft, directly behind the VGA timing
// controller. Two-stage pipeline: region flags, then colour. Syncs travel
// through matching registers so they line up with the RGB they belong to.
module elevator_pixel_gen
  import elevator_vga_pkg::*;
(
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  elevator_pixel_gen_if.slave  vga,
  input  logic [1:0]           sim_state,
  input  logic                 door_req,
  output logic [8:0]           car_y,
  output logic                 at_target
);

  localparam logic [9:0] L_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] L_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] L_SHAFT_L  = 10'(SHAFT_X0);
  localparam logic [9:0] L_SHAFT_R  = 10'(SHAFT_X0 + CAR_W);
  localparam logic [9:0] L_CENTRE   = 10'(CAR_CENTRE);
  localparam logic [9:0] L_CAR_H    = 10'(CAR_H);

  // ---------------- frame tick ----------------
  logic w_tick_match;
  logic r_tick_match;
  logic w_tick;

  assign w_tick_match = (vga.vert_count == L_V_ACTIVE) && (vga.horiz_count == 10'd0);
  // Only the first cycle of a match counts, even if the counters were to stall there
  assign w_tick       = w_tick_match && !r_tick_match;

  // Delayed match used to turn the counter compare into a single-cycle pulse
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_tick_match <= 1'b0;
    end else begin
      r_tick_match <= w_tick_match;
    end
  end

  // ---------------- car animation ----------------
  logic [8:0] w_car_y;
  logic [9:0] w_door_gap;
  logic       w_at_target;

  elevator_car_anim u_car_anim (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .i_tick      (w_tick),
    .i_sim_state (sim_state),
    .i_door_req  (door_req),
    .o_car_y     (w_car_y),
    .o_door_gap  (w_door_gap),
    .o_at_target (w_at_target)
  );

  assign car_y     = w_car_y;
  assign at_target = w_at_target;

  // ---------------- region decode ----------------
  logic [9:0]            w_car_y10;
  logic [9:0]            w_dx;
  logic [NUM_FLOORS-1:0] w_line_hit;
  pix_flags_t            w_flags;

  assign w_car_y10 = {1'b0, w_car_y};
  assign w_dx      = (vga.horiz_count >= L_CENTRE) ? (vga.horiz_count - L_CENTRE)
                                                   : (L_CENTRE - vga.horiz_count);

  // Floor separator rows sit on the last line of each floor band
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_line
    assign w_line_hit[gi] = (vga.vert_count == 10'((gi + 1) * FLOOR_H - 1));
  end

  assign w_flags.active        = (vga.horiz_count < L_H_ACTIVE) && (vga.vert_count < L_V_ACTIVE);
  assign w_flags.in_shaft      = (vga.horiz_count >= L_SHAFT_L) && (vga.horiz_count < L_SHAFT_R);
  assign w_flags.in_car        = w_flags.in_shaft && (vga.vert_count >= w_car_y10)
                                 && (vga.vert_count < (w_car_y10 + L_CAR_H));
  assign w_flags.in_gap        = w_flags.in_car && (w_dx < w_door_gap);
  assign w_flags.on_floor_line = w_flags.in_shaft && (|w_line_hit);

  // ---------------- stage 1: region flags + syncs ----------------
  pix_flags_t r_s1_flags;
  logic       r_s1_hsync;
  logic       r_s1_vsync;

  // Capture the region flags alongside the syncs of the same pixel
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_s1_flags <= '0;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
    end else begin
      r_s1_flags <= w_flags;
      r_s1_hsync <= vga.hsync_in;
      r_s1_vsync <= vga.vsync_in;
    end
  end

  // ---------------- stage 2: colour + syncs ----------------
  rgb12_t r_s2_rgb;
  logic   r_s2_hsync;
  logic   r_s2_vsync;

  // Resolve colour priority and register it with the second sync delay
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      r_s2_rgb   <= COLOUR_BLACK;
      r_s2_hsync <= 1'b1;
      r_s2_vsync <= 1'b1;
    end else begin
      r_s2_rgb   <= pixel_colour(r_s1_flags);
      r_s2_hsync <= r_s1_hsync;
      r_s2_vsync <= r_s1_vsync;
    end
  end

  assign vga.red       = r_s2_rgb.red;
  assign vga.green     = r_s2_rgb.green;
  assign vga.blue      = r_s2_rgb.blue;
  assign vga.hsync_out = r_s2_hsync;
  assign vga.vsync_out = r_s2_vsync;

endmodule

// File: tb/tb_elevator_pixel_gen.sv
// Bench for elevator_pixel_gen: directed pixel probes and frame ticks. Each probe
// pushes its hand-computed colour/sync into a scoreboard; a monitor pops and
// compares when the probe emerges from the pipeline.
module tb_elevator_pixel_gen;

  localparam logic [11:0] C_OFF   = 12'h000;
  localparam logic [11:0] C_GAP   = 12'hFC0;
  localparam logic [11:0] C_DOOR  = 12'h888;
  localparam logic [11:0] C_LINE  = 12'hFFF;
  localparam logic [11:0] C_SHAFT = 12'h004;

  logic       pixel_clk = 1'b0;
  logic       reset_n;
  logic [1:0] sim_state;
  logic       door_req;
  logic [8:0] car_y;
  logic       at_target;

  logic probe_v = 1'b0;
  logic v_d1    = 1'b0;
  logic v_d2    = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q [$];
  string       name_q [$];
  logic [13:0] mon_got;
  logic [13:0] mon_want;
  string       mon_name;

  elevator_pixel_gen_if vga_bus ();

  elevator_pixel_gen dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .vga       (vga_bus),
    .sim_state (sim_state),
    .door_req  (door_req),
    .car_y     (car_y),
    .at_target (at_target)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_idle();
    vga_bus.horiz_count = 10'd700;
    vga_bus.vert_count  = 10'd500;
    vga_bus.hsync_in    = 1'b1;
    vga_bus.vsync_in    = 1'b1;
  endtask

  // One pixel for one cycle; its expected output is queued for the monitor
  task automatic probe(input int x, input int y, input logic hs, input logic vs,
                       input logic [11:0] exp_rgb);
    @(posedge pixel_clk); #1;
    vga_bus.horiz_count = 10'(x);
    vga_bus.vert_count  = 10'(y);
    vga_bus.hsync_in    = hs;
    vga_bus.vsync_in    = vs;
    probe_v             = 1'b1;
    exp_q.push_back({exp_rgb, hs, vs});
    name_q.push_back($sformatf("pix(%0d,%0d)", x, y));
    @(posedge pixel_clk); #1;
    probe_v = 1'b0;
    set_idle();
  endtask

  // Present the frame-tick position for one cycle; animation state updates on that edge
  task automatic tick();
    @(posedge pixel_clk); #1;
    vga_bus.horiz_count = 10'd0;
    vga_bus.vert_count  = 10'd480;
    @(posedge pixel_clk); #1;
    set_idle();
  endtask

  // Probe-valid delay line: an output is due two edges after its probe was sampled
  always @(posedge pixel_clk) begin
    v_d1 <= probe_v;
    v_d2 <= v_d1;
  end

  // Monitor: compare the DUT output against the oldest queued expectation
  always @(negedge pixel_clk) begin
    if (v_d2) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: output presented with no expectation queued");
      end else begin
        mon_want = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_got  = {vga_bus.red, vga_bus.green, vga_bus.blue, vga_bus.hsync_out, vga_bus.vsync_out};
        if (mon_got != mon_want) begin
          bad++;
          $display("FAIL %s: got rgb=%03h hs=%0b vs=%0b, want rgb=%03h hs=%0b vs=%0b", mon_name,
                   mon_got[13:2], mon_got[1], mon_got[0], mon_want[13:2], mon_want[1], mon_want[0]);
        end else begin
          $display("ok %s rgb=%03h hs=%0b vs=%0b", mon_name, mon_got[13:2], mon_got[1], mon_got[0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset_n             = 1'b0;
    sim_state           = 2'd0;
    door_req            = 1'b0;
    vga_bus.horiz_count = 10'd300;
    vga_bus.vert_count  = 10'd380;
    vga_bus.hsync_in    = 1'b0;
    vga_bus.vsync_in    = 1'b0;

    // Reset state
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check("reset_rgb", int'({vga_bus.red, vga_bus.green, vga_bus.blue}), 0);
    check("reset_hsync_out", int'(vga_bus.hsync_out), 1);
    check("reset_vsync_out", int'(vga_bus.vsync_out), 1);
    check("reset_car_y", int'(car_y), 370);
    check("reset_at_target", int'(at_target), 1);
    @(posedge pixel_clk); #1;
    reset_n = 1'b1;
    set_idle();

    // Latency, sync alignment and region boundaries with the car parked at floor 0
    probe(300, 380, 1'b0, 1'b1, C_DOOR);
    probe(300, 380, 1'b1, 1'b0, C_DOOR);
    probe(275, 380, 1'b0, 1'b0, C_OFF);
    probe(300, 119, 1'b1, 1'b1, C_LINE);
    probe(300, 118, 1'b0, 1'b1, C_SHAFT);
    probe(300, 120, 1'b1, 1'b0, C_SHAFT);
    probe(300, 359, 1'b0, 1'b0, C_LINE);
    probe(300, 369, 1'b1, 1'b1, C_SHAFT);
    probe(300, 370, 1'b1, 1'b1, C_DOOR);
    probe(300, 469, 1'b1, 1'b1, C_DOOR);
    probe(300, 470, 1'b1, 1'b1, C_SHAFT);
    probe(300, 479, 1'b0, 1'b0, C_LINE);
    probe(359, 380, 1'b1, 1'b1, C_DOOR);
    probe(360, 380, 1'b1, 1'b1, C_OFF);
    probe(279, 100, 1'b1, 1'b1, C_OFF);
    probe(280, 100, 1'b1, 1'b1, C_SHAFT);
    probe(640, 380, 1'b0, 1'b0, C_OFF);
    probe(1000, 380, 1'b1, 1'b1, C_OFF);
    probe(300, 480, 1'b1, 1'b1, C_OFF);
    probe(320, 380, 1'b1, 1'b1, C_DOOR);

    // Doors open: gap grows 2 per tick to 40
    door_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      g = 2 * i;
      check($sformatf("open_car_y_%0d", i), int'(car_y), 370);
      probe(320 + g - 1, 380, 1'b1, 1'b1, C_GAP);
      probe(320 + g, 380, 1'b1, 1'b1, (g < 40) ? C_DOOR : C_OFF);
      probe(320 - g, 380, 1'b1, 1'b1, C_DOOR);
      probe(321 - g, 380, 1'b1, 1'b1, C_GAP);
    end
    tick();
    check("open_hold_at_target", int'(at_target), 1);
    probe(359, 380, 1'b1, 1'b1, C_GAP);

    // Doors close once the request drops
    door_req = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      g = 40 - 2 * j;
      check($sformatf("close_car_y_%0d", j), int'(car_y), 370);
      if (g > 0) probe(320 + g - 1, 380, 1'b1, 1'b1, C_GAP);
      probe(320 + g, 380, 1'b1, 1'b1, C_DOOR);
    end
    tick();
    check("closed_car_y", int'(car_y), 370);
    probe(320, 380, 1'b0, 1'b1, C_DOOR);

    // Retarget while open: doors close first, then the car heads for floor 3
    door_req = 1'b1;
    repeat (20) tick();
    probe(359, 380, 1'b1, 1'b1, C_GAP);
    check("retarget_open_at_target", int'(at_target), 1);
    sim_state = 2'd3;
    for (int k = 1; k <= 20; k++) begin
      tick();
      g = 40 - 2 * k;
      check($sformatf("retarget_hold_car_y_%0d", k), int'(car_y), 370);
      if (k == 1) check("retarget_at_target", int'(at_target), 0);
      if (g > 0) probe(320 + g - 1, 380, 1'b1, 1'b1, C_GAP);
      probe(320 + g, 380, 1'b1, 1'b1, C_DOOR);
    end
    for (int k = 21; k <= 140; k++) begin
      tick();
      check($sformatf("retarget_move_car_y_%0d", k), int'(car_y), 370 - (k - 20));
    end

    // Reset mid-move at car_y=250 returns the car home immediately
    @(posedge pixel_clk); #1;
    reset_n = 1'b0;
    @(posedge pixel_clk); #1;
    check("midmove_reset_car_y", int'(car_y), 370);
    check("midmove_reset_at_target", int'(at_target), 1);
    reset_n   = 1'b1;
    sim_state = 2'd0;
    door_req  = 1'b0;
    tick();
    check("after_reset_idle_car_y", int'(car_y), 370);
    probe(300, 380, 1'b0, 1'b0, C_DOOR);

    // Move up 0 -> 2: one line per frame, 240 frames
    sim_state = 2'd2;
    for (int i = 1; i <= 240; i++) begin
      tick();
      check($sformatf("up_car_y_%0d", i), int'(car_y), 370 - i);
      if (i == 1 || i == 239) check($sformatf("up_at_target_%0d", i), int'(at_target), 0);
    end
    check("up_arrived_at_target", int'(at_target), 1);
    tick();
    check("up_parked_car_y", int'(car_y), 130);
    probe(300, 130, 1'b1, 1'b1, C_DOOR);
    probe(300, 129, 1'b1, 1'b1, C_SHAFT);
    probe(300, 229, 1'b0, 1'b1, C_DOOR);
    probe(300, 230, 1'b1, 1'b0, C_SHAFT);
    probe(300, 239, 1'b1, 1'b1, C_LINE);
    probe(320, 130, 1'b1, 1'b1, C_DOOR);

    repeat (4) @(posedge pixel_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
